// File: rtl/reg_writeback_queue_if.sv
// Write-back bus: execute-unit enqueue lanes, register_file write port and
// queue status. The execute side is the master, the queue is the slave.
interface reg_writeback_queue_if;
  logic [1:0]       in_valid;
  logic             in_ready;
  logic [1:0]       in_word;
  logic [1:0][2:0]  in_reg;
  logic [1:0][15:0] in_data;
  logic [7:0][15:0] registers;
  logic             we;
  logic [2:0]       write_id;
  logic [15:0]      write_data;
  logic [7:0]       pending;
  logic             empty;

  modport master (
    output in_valid, in_word, in_reg, in_data, registers,
    input  in_ready, we, write_id, write_data, pending, empty
  );

  modport slave (
    input  in_valid, in_word, in_reg, in_data, registers,
    output in_ready, we, write_id, write_data, pending, empty
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// In-order GPR write-back queue in front of register_file. Takes up to two
// word/byte writes per cycle, pops one per cycle and turns byte writes into
// full 16-bit writes by merging with the current register value, forwarding
// the write that is still on its way into register_file.
module reg_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  reg_writeback_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [2:0]  idx;
    logic        word;
    logic        high;
    logic [15:0] data;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_we;
  logic [2:0]    r_write_id;
  logic [15:0]   r_write_data;

  logic          w_ready;
  logic          w_pop;
  logic [1:0]    w_acc;
  logic [CW-1:0] w_num_acc;
  logic [PW-1:0] w_wr_ptr1;
  entry_t        w_lane [2];
  entry_t        w_head;
  logic [15:0]   w_base;
  logic [15:0]   w_merged;
  logic [7:0]    w_pending;

  // No same-cycle credit from the pop: readiness looks only at the stored count.
  assign w_ready   = (CW'(DEPTH) - r_count) >= CW'(2);
  assign w_acc     = bus.in_valid & {2{w_ready}};
  assign w_num_acc = CW'(w_acc[0]) + CW'(w_acc[1]);
  // Lane1 lands right after lane0 when both are taken, else in lane0's slot.
  assign w_wr_ptr1 = r_wr_ptr + PW'(w_acc[0]);
  assign w_pop     = (r_count != '0);
  assign w_head    = r_mem[r_rd_ptr];

  // Map each lane's x86 register code to a word index and byte half.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      w_lane[l].idx  = bus.in_word[l] ? bus.in_reg[l] : {1'b0, bus.in_reg[l][1:0]};
      w_lane[l].word = bus.in_word[l];
      w_lane[l].high = bus.in_reg[l][2];
      w_lane[l].data = bus.in_data[l];
    end
  end

  // Merge the head entry with the newest value of its register; the write
  // presented this cycle has not reached register_file yet, so forward it.
  always_comb begin
    w_base = (r_we && (r_write_id == w_head.idx)) ? r_write_data
                                                  : bus.registers[w_head.idx];
    if (w_head.word)      w_merged = w_head.data;
    else if (w_head.high) w_merged = {w_head.data[7:0], w_base[7:0]};
    else                  w_merged = {w_base[15:8], w_head.data[7:0]};
  end

  // Pending mask: every live queue slot plus the write currently presented.
  always_comb begin
    logic [PW-1:0] v_off;
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_off = PW'(i) - r_rd_ptr;
      if ({1'b0, v_off} < r_count) w_pending[r_mem[i].idx] = 1'b1;
    end
    if (r_we) w_pending[r_write_id] = 1'b1;
  end

  // Queue storage; stale slots are harmless because pointers bound validity.
  always_ff @(posedge clk) begin
    if (w_acc[0]) r_mem[r_wr_ptr]  <= w_lane[0];
    if (w_acc[1]) r_mem[w_wr_ptr1] <= w_lane[1];
  end

  // Pointers, occupancy and the registered register_file write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_we         <= 1'b0;
      r_write_id   <= '0;
      r_write_data <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_num_acc);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + w_num_acc - CW'(w_pop);
      r_we    <= w_pop;
      if (w_pop) begin
        r_write_id   <= w_head.idx;
        r_write_data <= w_merged;
      end
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.we         = r_we;
  assign bus.write_id   = r_write_id;
  assign bus.write_data = r_write_data;
  assign bus.pending    = w_pending;
  assign bus.empty      = (r_count == '0) && !r_we;

endmodule
